// File: rtl/systolic_slice_skew_feeder.sv
// Ping-pong slice buffers for matrix A and B, replayed into a systolic array
// as a diagonally skewed wavefront (lane i lags lane 0 by i steps).
module systolic_slice_skew_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int ELEM_WIDTH = 8,
  parameter int SLICE_LEN  = 32
) (
  input  logic                                 s_clk,
  input  logic                                 s_rst,
  input  logic                                 MtrxA_slice_valid,
  input  logic [DATA_WIDTH-1:0]                MtrxA_slice_data,
  input  logic                                 MtrxA_slice_done,
  output logic                                 MtrxA_slice_ready,
  input  logic                                 MtrxB_slice_valid,
  input  logic [DATA_WIDTH-1:0]                MtrxB_slice_data,
  input  logic                                 MtrxB_slice_done,
  output logic                                 MtrxB_slice_ready,
  input  logic                                 sa_ready,
  output logic                                 sa_valid,
  output logic [DATA_WIDTH-1:0]                sa_a_data,
  output logic [DATA_WIDTH-1:0]                sa_b_data,
  output logic [DATA_WIDTH/ELEM_WIDTH-1:0]     sa_lane_vld,
  output logic                                 sa_first,
  output logic                                 sa_last,
  output logic [15:0]                          tile_cnt,
  output logic                                 proto_err
);
  localparam int LANES = DATA_WIDTH / ELEM_WIDTH;
  localparam int T     = SLICE_LEN + LANES - 1;
  localparam int CW    = $clog2(SLICE_LEN);
  localparam int SW    = $clog2(T);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              full_a_q, full_a_d, full_b_q, full_b_d;
  logic                    fill_a_q, fill_a_d, fill_b_q, fill_b_d;
  logic [CW-1:0]           cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic                    bank_q, bank_d;
  logic [SW-1:0]           step_q, step_d;
  logic [15:0]             tile_cnt_q, tile_cnt_d;
  logic                    proto_err_q, proto_err_d;
  logic                    vld_q, vld_d, first_q, first_d, last_q, last_d;
  logic [DATA_WIDTH-1:0]   a_out_q, a_out_d, b_out_q, b_out_d;
  logic [LANES-1:0]        lane_q, lane_d;

  logic [DATA_WIDTH-1:0]   mem_a [2][SLICE_LEN];
  logic [DATA_WIDTH-1:0]   mem_b [2][SLICE_LEN];

  logic                    a_beat, b_beat, a_end, b_end;
  logic                    tile_end, load, ld_bank;
  logic [SW-1:0]           ld_step;
  logic [DATA_WIDTH-1:0]   ld_a, ld_b;
  logic [LANES-1:0]        ld_vld;

  assign MtrxA_slice_ready = !full_a_q[fill_a_q];
  assign MtrxB_slice_ready = !full_b_q[fill_b_q];
  assign a_beat = MtrxA_slice_valid && MtrxA_slice_ready;
  assign b_beat = MtrxB_slice_valid && MtrxB_slice_ready;
  assign a_end  = a_beat && (cnt_a_q == CW'(SLICE_LEN - 1));
  assign b_end  = b_beat && (cnt_b_q == CW'(SLICE_LEN - 1));

  // Buffer contents survive reset on purpose; only the flags/pointers are cleared.
  always_ff @(posedge s_clk) begin
    if (a_beat) mem_a[fill_a_q][cnt_a_q] <= MtrxA_slice_data;
    if (b_beat) mem_b[fill_b_q][cnt_b_q] <= MtrxB_slice_data;
  end

  always_comb begin
    fill_a_d    = fill_a_q;
    fill_b_d    = fill_b_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    if (a_beat) begin
      if (a_end) begin
        cnt_a_d  = '0;
        fill_a_d = !fill_a_q;
      end else begin
        cnt_a_d  = cnt_a_q + CW'(1);
      end
    end
    if (b_beat) begin
      if (b_end) begin
        cnt_b_d  = '0;
        fill_b_d = !fill_b_q;
      end else begin
        cnt_b_d  = cnt_b_q + CW'(1);
      end
    end
    // done must coincide exactly with the final beat of a slice
    proto_err_d = proto_err_q || (MtrxA_slice_done != a_end) || (MtrxB_slice_done != b_end);
  end

  // Which step (and bank) the output registers load on this edge, if any.
  assign tile_end = (state_q == RUN) && sa_ready && (step_q == SW'(T - 1));

  always_comb begin
    load    = 1'b0;
    ld_bank = bank_q;
    ld_step = '0;
    if (state_q == IDLE) begin
      load = full_a_q[bank_q] && full_b_q[bank_q];
    end else if (sa_ready) begin
      if (tile_end) begin
        load    = full_a_q[!bank_q] && full_b_q[!bank_q];
        ld_bank = !bank_q;
      end else begin
        load    = 1'b1;
        ld_step = step_q + SW'(1);
      end
    end
  end

  always_comb begin
    ld_a   = '0;
    ld_b   = '0;
    ld_vld = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((int'(ld_step) >= i) && (int'(ld_step) - i < SLICE_LEN)) begin
        ld_vld[i] = 1'b1;
        ld_a[i*ELEM_WIDTH +: ELEM_WIDTH] =
          mem_a[ld_bank][CW'(int'(ld_step) - i)][i*ELEM_WIDTH +: ELEM_WIDTH];
        ld_b[i*ELEM_WIDTH +: ELEM_WIDTH] =
          mem_b[ld_bank][CW'(int'(ld_step) - i)][i*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    step_d     = step_q;
    tile_cnt_d = tile_cnt_q;
    full_a_d   = full_a_q;
    full_b_d   = full_b_q;
    vld_d      = vld_q;
    first_d    = first_q;
    last_d     = last_q;
    a_out_d    = a_out_q;
    b_out_d    = b_out_q;
    lane_d     = lane_q;
    if (tile_end) begin
      full_a_d[bank_q] = 1'b0;
      full_b_d[bank_q] = 1'b0;
      bank_d           = !bank_q;
      tile_cnt_d       = tile_cnt_q + 16'd1;
      if (!load) begin
        state_d = IDLE;
        vld_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        a_out_d = '0;
        b_out_d = '0;
        lane_d  = '0;
      end
    end
    if (load) begin
      state_d = RUN;
      vld_d   = 1'b1;
      step_d  = ld_step;
      first_d = (ld_step == '0);
      last_d  = (ld_step == SW'(T - 1));
      a_out_d = ld_a;
      b_out_d = ld_b;
      lane_d  = ld_vld;
    end
    // fill never completes into a bank that is being freed, so order is irrelevant
    if (a_end) full_a_d[fill_a_q] = 1'b1;
    if (b_end) full_b_d[fill_b_q] = 1'b1;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q     <= IDLE;
      full_a_q    <= '0;
      full_b_q    <= '0;
      fill_a_q    <= 1'b0;
      fill_b_q    <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      bank_q      <= 1'b0;
      step_q      <= '0;
      tile_cnt_q  <= '0;
      proto_err_q <= 1'b0;
      vld_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      full_a_q    <= full_a_d;
      full_b_q    <= full_b_d;
      fill_a_q    <= fill_a_d;
      fill_b_q    <= fill_b_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      bank_q      <= bank_d;
      step_q      <= step_d;
      tile_cnt_q  <= tile_cnt_d;
      proto_err_q <= proto_err_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      lane_q      <= lane_d;
    end
  end

  assign sa_valid    = vld_q;
  assign sa_a_data   = a_out_q;
  assign sa_b_data   = b_out_q;
  assign sa_lane_vld = lane_q;
  assign sa_first    = first_q;
  assign sa_last     = last_q;
  assign tile_cnt    = tile_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_systolic_slice_skew_feeder.sv
// Directed bench for the skew feeder: skew pattern, latency, backpressure,
// ping-pong overlap, done-protocol error and reset mid-drain.
module tb_systolic_slice_skew_feeder;
  localparam int SL = 32;
  localparam int T  = 39;

  logic        clk = 1'b0;
  logic        s_rst;
  logic        a_valid, a_done, a_ready, b_valid, b_done, b_ready;
  logic [63:0] a_data, b_data;
  logic        sa_ready, sa_valid, sa_first, sa_last, proto_err;
  logic [63:0] sa_a_data, sa_b_data;
  logic [7:0]  sa_lane_vld;
  logic [15:0] tile_cnt;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int first_vld_cyc = -1;
  int ready_low_cnt = 0;
  int rise_checks = 0;

  systolic_slice_skew_feeder dut (
    .s_clk(clk), .s_rst(s_rst),
    .MtrxA_slice_valid(a_valid), .MtrxA_slice_data(a_data),
    .MtrxA_slice_done(a_done), .MtrxA_slice_ready(a_ready),
    .MtrxB_slice_valid(b_valid), .MtrxB_slice_data(b_data),
    .MtrxB_slice_done(b_done), .MtrxB_slice_ready(b_ready),
    .sa_ready(sa_ready), .sa_valid(sa_valid), .sa_a_data(sa_a_data),
    .sa_b_data(sa_b_data), .sa_lane_vld(sa_lane_vld), .sa_first(sa_first),
    .sa_last(sa_last), .tile_cnt(tile_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [63:0] word_a(input int seed, input int k);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'((k*8 + i + seed) & 255);
    return w;
  endfunction

  function automatic logic [63:0] word_b(input int seed, input int k);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(255 - ((k*8 + i + seed) & 255));
    return w;
  endfunction

  function automatic void model(input int seed, input int t, output logic [63:0] ea,
                                output logic [63:0] eb, output logic [7:0] ev);
    logic [63:0] wa, wb;
    ea = '0; eb = '0; ev = '0;
    for (int i = 0; i < 8; i++) begin
      if (t - i >= 0 && t - i < SL) begin
        wa = word_a(seed, t - i);
        wb = word_b(seed, t - i);
        ev[i] = 1'b1;
        ea[i*8 +: 8] = wa[i*8 +: 8];
        eb[i*8 +: 8] = wb[i*8 +: 8];
      end
    end
  endfunction

  task automatic do_reset();
    s_rst = 1'b1; sa_ready = 1'b0;
    a_valid = 1'b0; a_done = 1'b0; a_data = '0;
    b_valid = 1'b0; b_done = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b0;
    first_vld_cyc = -1;
  endtask

  // Presents one word per cycle whenever the port is ready; done only on the beat itself.
  task automatic feed(input bit is_b, input int seed0, input int nsl, input int bad_beat,
                      output int last_edge, output int bad_edge, output bit tmo);
    int k, c;
    logic rdy;
    k = 0; c = 0; last_edge = 0; bad_edge = 0;
    while (k < nsl*SL && c < 4000) begin
      @(negedge clk); c++;
      rdy = is_b ? b_ready : a_ready;
      if (rdy === 1'b1) begin
        if (is_b) begin
          b_valid = 1'b1; b_data = word_b(seed0 + k/SL, k%SL);
          b_done = (k%SL == SL-1) || (k%SL == bad_beat);
        end else begin
          a_valid = 1'b1; a_data = word_a(seed0 + k/SL, k%SL);
          a_done = (k%SL == SL-1) || (k%SL == bad_beat);
        end
        @(posedge clk); #1;
        if (is_b) begin b_valid = 1'b0; b_done = 1'b0; end
        else begin a_valid = 1'b0; a_done = 1'b0; end
        if (k%SL == bad_beat) bad_edge = cyc_cnt;
        last_edge = cyc_cnt;
        k++;
      end
    end
    tmo = (k < nsl*SL);
  endtask

  // Drives sa_ready and checks every presented step against the model.
  task automatic drain_check(input int ntiles, input int seed0, input bit bp, input bit nogap,
                             input int stop_step, output int acc);
    int t, tile, c;
    bit stall, want_first, want_ra, want_rb, stop;
    logic [63:0] pa, pb, ea, eb;
    logic [7:0] pv, ev;
    logic pf, pl;
    t = 0; tile = 0; c = 0; acc = 0; stop = 0;
    stall = 0; want_first = 0; want_ra = 0; want_rb = 0;
    pa = '0; pb = '0; pv = '0; pf = 0; pl = 0;
    while (tile < ntiles && !stop && c < 3000) begin
      @(negedge clk); c++;
      sa_ready = bp ? ((c%4 == 1) || (c%4 == 0)) : 1'b1;
      if (a_ready === 1'b0) ready_low_cnt++;
      if (stall) begin
        total++;
        if ({sa_valid, sa_a_data, sa_b_data, sa_lane_vld, sa_first, sa_last} !== {1'b1, pa, pb, pv, pf, pl}) begin
          bad++; $display("FAIL hold t=%0d: got a=%h vld=%h, required a=%h vld=%h", t, sa_a_data, sa_lane_vld, pa, pv);
        end
      end
      if (want_first) begin
        total++;
        if (sa_valid !== 1'b1 || sa_first !== 1'b1) begin
          bad++; $display("FAIL nogap tile=%0d: got valid=%b first=%b, required 1 1", tile, sa_valid, sa_first);
        end
      end
      if (want_ra || want_rb) begin
        total++; rise_checks++;
        if ((want_ra && a_ready !== 1'b1) || (want_rb && b_ready !== 1'b1)) begin
          bad++; $display("FAIL ready_rise: got a=%b b=%b, required 1", a_ready, b_ready);
        end
      end
      want_first = 0; want_ra = 0; want_rb = 0;
      if (sa_valid === 1'b1) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc_cnt;
        model(seed0 + tile, t, ea, eb, ev);
        total++;
        if (sa_a_data !== ea || sa_b_data !== eb || sa_lane_vld !== ev ||
            sa_first !== (t == 0) || sa_last !== (t == T-1)) begin
          bad++;
          $display("FAIL step tile=%0d t=%0d: got a=%h b=%h vld=%h f=%b l=%b, required a=%h b=%h vld=%h f=%b l=%b",
                   tile, t, sa_a_data, sa_b_data, sa_lane_vld, sa_first, sa_last, ea, eb, ev, t == 0, t == T-1);
        end
        if (t == stop_step) stop = 1;
        else if (sa_ready) begin
          acc++;
          if (t == T-1) begin
            t = 0; tile++;
            want_first = nogap && (tile < ntiles);
            want_ra = (a_ready === 1'b0);
            want_rb = (b_ready === 1'b0);
          end else t++;
        end
      end
      stall = (sa_valid === 1'b1) && !sa_ready;
      pa = sa_a_data; pb = sa_b_data; pv = sa_lane_vld; pf = sa_first; pl = sa_last;
    end
    if (!stop && tile < ntiles) begin
      total++; bad++; $display("FAIL drain_timeout: got %0d tiles, required %0d", tile, ntiles);
    end
  endtask

  task automatic check_tmo(input string nm, input bit tmo);
    total++;
    if (tmo) begin bad++; $display("FAIL %s feed_timeout: got stalled, required completion", nm); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({sa_valid, sa_a_data, sa_b_data, sa_lane_vld, sa_first, sa_last, tile_cnt, proto_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got valid=%b vld=%h cnt=%0d err=%b, required all 0", sa_valid, sa_lane_vld, tile_cnt, proto_err);
    end
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got a=%b b=%b, required 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_single_tile();
    int la, lb, x, acc;
    bit ta, tb;
    do_reset();
    fork
      feed(0, 0, 1, -1, la, x, ta);
      begin repeat (5) @(negedge clk); feed(1, 0, 1, -1, lb, x, tb); end
      drain_check(1, 0, 0, 0, -1, acc);
    join
    check_tmo("single_a", ta);
    check_tmo("single_b", tb);
    total++;
    if (first_vld_cyc != lb + 1) begin
      bad++; $display("FAIL latency: got first valid edge %0d, required %0d", first_vld_cyc, lb + 1);
    end
    total++;
    if (acc != T) begin bad++; $display("FAIL single_steps: got %0d, required %0d", acc, T); end
    @(negedge clk);
    total++;
    if (tile_cnt !== 16'd1 || sa_valid !== 1'b0) begin
      bad++; $display("FAIL single_end: got cnt=%0d valid=%b, required 1 0", tile_cnt, sa_valid);
    end
  endtask

  task automatic test_backpressure();
    int la, lb, x, acc;
    bit ta, tb;
    do_reset();
    fork
      feed(0, 0, 1, -1, la, x, ta);
      feed(1, 0, 1, -1, lb, x, tb);
      drain_check(1, 0, 1, 0, -1, acc);
    join
    check_tmo("bp_a", ta);
    check_tmo("bp_b", tb);
    total++;
    if (acc != T) begin bad++; $display("FAIL bp_steps: got %0d, required %0d", acc, T); end
    @(negedge clk);
    total++;
    if (tile_cnt !== 16'd1) begin bad++; $display("FAIL bp_tile_cnt: got %0d, required 1", tile_cnt); end
  endtask

  task automatic test_ping_pong();
    int la, lb, x, acc;
    bit ta, tb;
    do_reset();
    ready_low_cnt = 0; rise_checks = 0;
    fork
      feed(0, 10, 4, -1, la, x, ta);
      feed(1, 10, 4, -1, lb, x, tb);
      drain_check(4, 10, 0, 1, -1, acc);
    join
    check_tmo("pp_a", ta);
    check_tmo("pp_b", tb);
    total++;
    if (acc != 4*T) begin bad++; $display("FAIL pp_steps: got %0d, required %0d", acc, 4*T); end
    total++;
    if (ready_low_cnt == 0 || rise_checks == 0) begin
      bad++; $display("FAIL pp_ready_drop: got low=%0d rise=%0d, required both >0", ready_low_cnt, rise_checks);
    end
    @(negedge clk);
    total++;
    if (tile_cnt !== 16'd4) begin bad++; $display("FAIL pp_tile_cnt: got %0d, required 4", tile_cnt); end
  endtask

  task automatic test_protocol();
    int la, lb, be, x, acc, err_cyc;
    bit ta, tb;
    do_reset();
    err_cyc = -1;
    fork
      feed(0, 20, 1, 15, la, be, ta);
      feed(1, 20, 1, -1, lb, x, tb);
      drain_check(1, 20, 0, 0, -1, acc);
      begin
        for (int c = 0; c < 200 && proto_err !== 1'b1; c++) @(negedge clk);
        err_cyc = cyc_cnt;
      end
    join
    check_tmo("proto_a", ta);
    check_tmo("proto_b", tb);
    total++;
    if (err_cyc != be) begin bad++; $display("FAIL proto_timing: got edge %0d, required %0d", err_cyc, be); end
    @(negedge clk);
    total++;
    if (proto_err !== 1'b1 || tile_cnt !== 16'd1) begin
      bad++; $display("FAIL proto_sticky: got err=%b cnt=%0d, required 1 1", proto_err, tile_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    int la, lb, x, acc;
    bit ta, tb;
    do_reset();
    fork
      feed(0, 30, 1, -1, la, x, ta);
      feed(1, 30, 1, -1, lb, x, tb);
      drain_check(1, 30, 0, 0, 20, acc);
    join
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    total++;
    if (sa_valid !== 1'b0 || sa_lane_vld !== 8'h00 || tile_cnt !== 16'd0 || a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset: got valid=%b vld=%h cnt=%0d rdy=%b%b, required 0 00 0 11",
                      sa_valid, sa_lane_vld, tile_cnt, a_ready, b_ready);
    end
    fork
      feed(0, 40, 1, -1, la, x, ta);
      feed(1, 40, 1, -1, lb, x, tb);
      drain_check(1, 40, 0, 0, -1, acc);
    join
    check_tmo("rst_a", ta);
    check_tmo("rst_b", tb);
    @(negedge clk);
    total++;
    if (tile_cnt !== 16'd1 || acc != T) begin
      bad++; $display("FAIL post_reset_tile: got cnt=%0d steps=%0d, required 1 %0d", tile_cnt, acc, T);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_ping_pong();
    test_protocol();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
